uart_msg_sender: RTL and testbench

- Parametrised successor to the fixed ID sender.
- Streams a configurable byte message from a parameter-initialised ROM into the UART TX path over a valid/ready handshake.
- Supports single-shot and repeat modes, a runtime length override, programmable inter-byte gap and clean abort.
- Sits between the ex-stage control (start/abort) and the UART transmitter; no longer infers progress from CPU status-register reads.

---
 rtl/msg_sender_pkg.sv | 27 ++
 rtl/uart_msg_sender_if.sv | 26 ++
 rtl/msg_rom.sv | 28 ++
 rtl/uart_msg_sender.sv | 178 +++++++++++++++++
 tb/tb_uart_msg_sender.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_sender_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// msg_sender_pkg : shared types and constants for the message sender
// Rev 1.0
// ------------------------------------------------------------------
package msg_sender_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_MSG_LEN = 10;

  // byte0 sits in the LSBs, so the string reads back-to-front on the wire
  localparam logic [DEFAULT_MSG_LEN*BYTE_W-1:0] DEFAULT_ID_MSG = "3101123202";

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int idx_width(input int count);
    int w;
    w = $clog2(count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_msg_sender_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_msg_sender_if : byte valid/ready handshake towards the UART TX
// Rev 1.0
// ------------------------------------------------------------------
interface uart_msg_sender_if;
  import msg_sender_pkg::*;

  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/msg_rom.sv
`default_nettype none
// ------------------------------------------------------------------
// msg_rom : parameter-initialised message ROM, combinational read
// Rev 1.0
// ------------------------------------------------------------------
module msg_rom
  import msg_sender_pkg::*;
#(
  parameter int                         MSG_LEN = DEFAULT_MSG_LEN,
  parameter logic [MSG_LEN*BYTE_W-1:0]  MSG     = DEFAULT_ID_MSG,
  parameter int                         IDX_W   = idx_width(MSG_LEN)
) (
  input  logic [IDX_W-1:0]  addr_i,
  output logic [BYTE_W-1:0] byte_o
);

  // Addresses past the message read as zero
  always_comb begin
    byte_o = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (addr_i == IDX_W'(i)) begin
        byte_o = MSG[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_msg_sender.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_msg_sender : streams a ROM message into the UART TX handshake
// Rev 1.0
// ------------------------------------------------------------------
module uart_msg_sender
  import msg_sender_pkg::*;
#(
  parameter int                         MSG_LEN    = DEFAULT_MSG_LEN,
  parameter logic [MSG_LEN*BYTE_W-1:0]  MSG        = DEFAULT_ID_MSG,
  parameter int                         GAP_CYCLES = 0,
  parameter int                         IDX_W      = idx_width(MSG_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                repeat_i,
  input  logic [IDX_W-1:0]    len_i,
  uart_msg_sender_if.master   tx,
  output logic                busy_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                done_o,
  output logic                aborted_o
);

  localparam int               GAP_W      = idx_width(GAP_CYCLES);
  localparam bit               C_HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [IDX_W-1:0] C_MSG_LEN  = IDX_W'(MSG_LEN);
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  len_q;
  logic [GAP_W-1:0]  gap_q;
  logic              abort_q;
  logic              tx_valid_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;

  logic [IDX_W-1:0]  eff_len_d;
  logic [IDX_W-1:0]  idx_inc_d;
  logic [IDX_W-1:0]  rom_addr_d;
  logic [BYTE_W-1:0] rom_byte_d;
  logic              accept_d;
  logic              last_d;
  logic              abort_now_d;

  msg_rom #(
    .MSG_LEN (MSG_LEN),
    .MSG     (MSG),
    .IDX_W   (IDX_W)
  ) u_rom (
    .addr_i  (rom_addr_d),
    .byte_o  (rom_byte_d)
  );

  // The ROM is addressed with the index the data register will hold next
  always_comb begin
    eff_len_d = len_i;
    if ((len_i == '0) || (len_i > C_MSG_LEN)) begin
      eff_len_d = C_MSG_LEN;
    end
    accept_d    = tx_valid_q & tx.tx_ready;
    last_d      = (idx_q == (len_q - 1'b1));
    abort_now_d = abort_q | abort_i;
    idx_inc_d   = idx_q + 1'b1;
    rom_addr_d  = '0;
    case (state_q)
      ST_SEND: rom_addr_d = last_d ? '0 : idx_inc_d;
      ST_GAP:  rom_addr_d = idx_q;
      default: rom_addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      abort_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q      <= eff_len_d;
            idx_q      <= '0;
            gap_q      <= '0;
            abort_q    <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= rom_byte_d;
            busy_q     <= 1'b1;
            state_q    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (accept_d) begin
            if (last_d && repeat_i && !abort_now_d) begin
              done_q <= 1'b1;
              idx_q  <= '0;
              if (C_HAS_GAP) begin
                tx_valid_q <= 1'b0;
                gap_q      <= '0;
                state_q    <= ST_GAP;
              end else begin
                tx_data_q <= rom_byte_d;
              end
            end else if (last_d || abort_now_d) begin
              // A last byte always reports done, even with an abort pending
              done_q     <= last_d;
              aborted_q  <= ~last_d;
              idx_q      <= '0;
              abort_q    <= 1'b0;
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              busy_q     <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              idx_q <= idx_inc_d;
              if (C_HAS_GAP) begin
                tx_valid_q <= 1'b0;
                gap_q      <= '0;
                state_q    <= ST_GAP;
              end else begin
                tx_data_q <= rom_byte_d;
              end
            end
          end else if (abort_i) begin
            abort_q <= 1'b1;
          end
        end

        ST_GAP: begin
          if (abort_now_d) begin
            aborted_q  <= 1'b1;
            idx_q      <= '0;
            gap_q      <= '0;
            abort_q    <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (gap_q == C_GAP_LAST) begin
            gap_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= rom_byte_d;
            state_q    <= ST_SEND;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;
  assign busy_o      = busy_q;
  assign idx_o       = idx_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_sender.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_msg_sender : directed + randomized bench, GAP=0 and GAP=2
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_msg_sender;

  localparam int LEN  = 10;
  localparam int IW   = 4;
  localparam int GAP2 = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          rpt;
  logic          ready;
  logic [IW-1:0] len;

  logic          busy0, done0, ab0;
  logic          busy2, done2, ab2;
  logic [IW-1:0] idx0, idx2;

  always #5 clk = ~clk;

  uart_msg_sender_if if0 ();
  uart_msg_sender_if if2 ();
  assign if0.tx_ready = ready;
  assign if2.tx_ready = ready;

  uart_msg_sender #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .repeat_i(rpt),
    .len_i(len), .tx(if0), .busy_o(busy0), .idx_o(idx0), .done_o(done0),
    .aborted_o(ab0)
  );

  uart_msg_sender #(.GAP_CYCLES(GAP2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .repeat_i(rpt),
    .len_i(len), .tx(if2), .busy_o(busy2), .idx_o(idx2), .done_o(done2),
    .aborted_o(ab2)
  );

  // Reference message, written out byte by byte
  logic [7:0] ref_msg [LEN] = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h32,
                                8'h31, 8'h31, 8'h30, 8'h31, 8'h33};

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         s_cyc = 0;
  bit         rnd_ready = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q2[$];
  int         qi0[$];
  int         done_n0 = 0, ab_n0 = 0, done_cyc0 = 0;
  int         done_n2 = 0, ab_n2 = 0, done_cyc2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.tx_valid && ready) begin
      q0.push_back(if0.tx_data);
      qi0.push_back(int'(idx0));
    end
    if (if2.tx_valid && ready) q2.push_back(if2.tx_data);
    if (done0) begin done_n0++; done_cyc0 = cyc; end
    if (ab0) ab_n0++;
    if (done2) begin done_n2++; done_cyc2 = cyc; end
    if (ab2) ab_n2++;
  end

  function automatic int ref_len(input int l);
    return (l == 0 || l > LEN) ? LEN : l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    q0.delete(); q2.delete(); qi0.delete();
    done_n0 = 0; ab_n0 = 0; done_n2 = 0; ab_n2 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic start_msg();
    start = 1'b1; tick(); start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_idle0(input int max);
    int n = 0;
    while (busy0 === 1'b1 && n < max) begin
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    check("idle0_timeout", 32'(busy0), 32'd0);
  endtask

  task automatic wait_idle2(input int max);
    int n = 0;
    while (busy2 === 1'b1 && n < max) begin
      tick(); n++;
    end
    check("idle2_timeout", 32'(busy2), 32'd0);
  endtask

  // Model: a run of reps passes over the first elen bytes of the message
  task automatic check_stream(input string tag, input int elen, input int reps, input bit use2);
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    for (int p = 0; p < reps; p++)
      for (int i = 0; i < elen; i++) exp_q.push_back(ref_msg[i]);
    if (use2) got = q2; else got = q0;
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int n;
    int k;
    int l;
    logic [6:0] vpat;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rpt = 1'b0; ready = 1'b1; len = '0;
    tick(); tick();

    // Reset state
    check("rst_valid", 32'(if0.tx_valid), 32'd0);
    check("rst_data", 32'(if0.tx_data), 32'd0);
    check("rst_status", 32'({busy0, idx0, done0, ab0}), 32'd0);

    // Single shot, full throughput, exact cycle timing
    rst = 1'b0; tick(); clr();
    start_msg();
    for (int i = 0; i < LEN; i++) begin
      check("t1_present", 32'({if0.tx_valid, if0.tx_data, idx0, busy0}),
            32'({1'b1, ref_msg[i], IW'(i), 1'b1}));
      tick();
    end
    check("t1_done", 32'({done0, busy0, if0.tx_valid, ab0}), 32'b1000);
    tick();
    check("t1_done_pulse", 32'(done0), 32'd0);
    check_stream("t1", LEN, 1, 1'b0);

    // Backpressure for three cycles on byte 4
    clr();
    start_msg();
    n = 0;
    while (idx0 != IW'(4) && n < 20) begin tick(); n++; end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", 32'({if0.tx_valid, if0.tx_data, idx0}), 32'({1'b1, ref_msg[4], IW'(4)}));
    end
    ready = 1'b1;
    wait_idle0(40); tick();
    check_stream("bp", LEN, 1, 1'b0);
    check("bp_done_n", 32'(done_n0), 32'd1);
    check("bp_latency", 32'(done_cyc0 - s_cyc), 32'(LEN + 3));

    // GAP=2, len 3, stray start mid-message
    do_reset(); clr();
    len = IW'(3);
    start_msg();
    vpat = '0;
    for (int j = 0; j < 7; j++) begin
      vpat[j] = if2.tx_valid;
      if (j == 1) check("gap_idx", 32'(idx2), 32'd1);
      start = (j == 2);
      tick();
    end
    start = 1'b0;
    wait_idle2(20); tick();
    for (int j = 0; j < 7; j++) check("gap_valid", 32'(vpat[j]), 32'((j % (GAP2 + 1)) == 0));
    check_stream("gap", 3, 1, 1'b1);
    check("gap_done_n", 32'({done_n2, ab_n2}), 32'({32'd1, 32'd0}));
    check("gap_latency", 32'(done_cyc2 - s_cyc), 32'(3 + GAP2 * 2));

    // Repeat two passes under random backpressure
    do_reset(); clr();
    len = '0; rpt = 1'b1; rnd_ready = 1'b1;
    start_msg();
    n = 0;
    while (!done0 && n < 300) begin
      ready = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    check("rep_first_done", 32'(done0), 32'd1);
    rpt = 1'b0;
    wait_idle0(300); tick();
    rnd_ready = 1'b0; ready = 1'b1;
    check_stream("rep", LEN, 2, 1'b0);
    for (int i = 0; i < qi0.size(); i++) check("rep_idx", 32'(qi0[i]), 32'(i % LEN));
    check("rep_events", 32'({done_n0[15:0], ab_n0[15:0]}), 32'({16'd2, 16'd0}));

    // Abort under backpressure at a random byte
    do_reset(); clr();
    len = '0; rpt = 1'b0; ready = 1'b1;
    k = $urandom_range(1, 8);
    start_msg();
    n = 0;
    while (idx0 != IW'(k) && n < 20) begin tick(); n++; end
    ready = 1'b0; abort = 1'b1; tick(); abort = 1'b0; tick(); tick();
    check("ab_hold", 32'({if0.tx_valid, if0.tx_data, idx0, busy0}), 32'({1'b1, ref_msg[k], IW'(k), 1'b1}));
    ready = 1'b1; tick();
    check("ab_flags", 32'({ab0, done0, busy0, if0.tx_valid}), 32'b1000);
    tick(); tick();
    check_stream("ab", k + 1, 1, 1'b0);
    check("ab_events", 32'({done_n0[15:0], ab_n0[15:0]}), 32'({16'd0, 16'd1}));

    // Abort together with the last byte: done only, no repeat
    do_reset(); clr();
    l = $urandom_range(1, 9);
    len = IW'(l); rpt = 1'b1; ready = 1'b1;
    start_msg();
    n = 0;
    while (idx0 != IW'(l - 1) && n < 20) begin tick(); n++; end
    abort = 1'b1; tick(); abort = 1'b0;
    check("ablast_flags", 32'({done0, ab0, busy0, if0.tx_valid}), 32'b1000);
    tick(); tick();
    rpt = 1'b0;
    check_stream("ablast", l, 1, 1'b0);
    check("ablast_events", 32'({done_n0[15:0], ab_n0[15:0]}), 32'({16'd1, 16'd0}));

    // Runtime length override, including 1 and out-of-range values
    for (int it = 0; it < 4; it++) begin
      do_reset(); clr();
      if (it == 0) l = 1;
      else if (it == 1) l = $urandom_range(11, 15);
      else l = $urandom_range(0, 15);
      len = IW'(l); rnd_ready = 1'b1;
      start_msg();
      wait_idle0(300); tick();
      rnd_ready = 1'b0; ready = 1'b1;
      check_stream("len", ref_len(l), 1, 1'b0);
      check("len_done_n", 32'(done_n0), 32'd1);
    end

    // Reset mid-message drops the pending byte; restart begins at byte 0
    do_reset(); clr();
    len = '0;
    start_msg();
    tick(); tick(); tick();
    check("mid_valid", 32'({if0.tx_valid, busy0}), 32'b11);
    rst = 1'b1; tick();
    check("mid_rst", 32'({if0.tx_valid, if0.tx_data, busy0, idx0, done0, ab0}), 32'd0);
    rst = 1'b0; tick();
    start_msg();
    check("mid_restart", 32'({if0.tx_valid, if0.tx_data, idx0}), 32'({1'b1, ref_msg[0], IW'(0)}));
    wait_idle0(40); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
